// File: rtl/elevator_motion_scheduler_if.sv
// rtl/elevator_motion_scheduler_if.sv - car control bundle: tick/call inputs, motion/door status outputs
interface elevator_motion_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic                  tick;
  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output tick, req,
    input  current_floor, moving, dir_up, door_open, pending
  );

  modport slave (
    input  tick, req,
    output current_floor, moving, dir_up, door_open, pending
  );
endinterface

// File: rtl/elevator_motion_scheduler.sv
// rtl/elevator_motion_scheduler.sv - SCAN car scheduler: latches calls, times travel and door dwell in ticks
module elevator_motion_scheduler #(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_W      = 2,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 6,
  parameter int CNT_W        = 8
) (
  input  logic                       clk_in,
  input  logic                       rst,
  elevator_motion_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_e;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]      travel_cnt_q, travel_cnt_d;
  logic [CNT_W-1:0]      door_cnt_q, door_cnt_d;

  logic [FLOOR_W-1:0]    floor_nx;
  logic [NUM_FLOORS-1:0] here_mask, set_mask, clr_mask, beyond_mask;
  logic                  here, above, below, going_up;

  function automatic logic [NUM_FLOORS-1:0] floor_sel(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) == f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floors_above(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floors_below(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_up_d     = dir_up_q;
    travel_cnt_d = travel_cnt_q;
    door_cnt_d   = door_cnt_q;
    here_mask    = floor_sel(floor_q);
    here         = |(pending_q & here_mask);
    above        = |(pending_q & floors_above(floor_q));
    below        = |(pending_q & floors_below(floor_q));
    going_up     = (state_q == MOVE_UP);
    floor_nx     = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    beyond_mask  = going_up ? floors_above(floor_nx) : floors_below(floor_nx);
    set_mask     = bus.req;
    clr_mask     = '0;

    case (state_q)
      IDLE: begin
        if (here) begin
          state_d    = DOOR;
          clr_mask   = here_mask;
          door_cnt_d = '0;
        end else if (above && (dir_up_q || !below)) begin
          state_d      = MOVE_UP;
          dir_up_d     = 1'b1;
          travel_cnt_d = '0;
        end else if (below) begin
          state_d      = MOVE_DOWN;
          dir_up_d     = 1'b0;
          travel_cnt_d = '0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (bus.tick) begin
          if (travel_cnt_q == TRAVEL_LAST) begin
            floor_d      = floor_nx;
            travel_cnt_d = '0;
            // Arrival decisions use the calls latched before this cycle's req.
            if (|(pending_q & floor_sel(floor_nx))) begin
              state_d    = DOOR;
              clr_mask   = floor_sel(floor_nx);
              door_cnt_d = '0;
            end else if (!(|(pending_q & beyond_mask))) begin
              state_d = IDLE;
            end
          end else begin
            travel_cnt_d = travel_cnt_q + CNT_W'(1);
          end
        end
      end
      DOOR: begin
        // A call to the open floor is absorbed as a dwell extension.
        set_mask = bus.req & ~here_mask;
        if (|(bus.req & here_mask)) begin
          door_cnt_d = '0;
        end else if (bus.tick) begin
          if (door_cnt_q == DOOR_LAST) state_d = IDLE;
          else door_cnt_d = door_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      floor_q      <= '0;
      dir_up_q     <= 1'b1;
      pending_q    <= '0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_up_q     <= dir_up_d;
      pending_q    <= pending_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  assign bus.current_floor = floor_q;
  assign bus.moving        = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign bus.door_open     = (state_q == DOOR);
  assign bus.dir_up        = dir_up_q;
  assign bus.pending       = pending_q;
endmodule

// File: tb/tb_elevator_motion_scheduler.sv
// tb/tb_elevator_motion_scheduler.sv - directed and randomized checks against a behavioural car model
module tb_elevator_motion_scheduler;
  localparam int NF = 4;
  localparam int FW = 2;
  localparam int TT = 2;
  localparam int DT = 3;
  localparam int CW = 8;
  localparam int VW = FW + 3 + NF;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  elevator_motion_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_motion_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Model: motion is -1/0/+1, door_left counts remaining open ticks (0 = closed),
  // travel_left counts remaining ticks until the next floor is reached.
  int m_floor, m_motion, m_door_left, m_travel_left;
  bit m_up;
  bit m_pend[NF];

  function automatic bit beyond(input bit p[NF], input int f, input int d);
    for (int i = 0; i < NF; i++) if (p[i] && (i - f) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_floor = 0; m_motion = 0; m_door_left = 0; m_travel_left = 0; m_up = 1'b1;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endfunction

  function automatic void model_step(input logic [NF-1:0] r, input logic t);
    bit old[NF];
    bit a, b;
    old = m_pend;
    for (int i = 0; i < NF; i++)
      if (r[i] && !(m_door_left > 0 && i == m_floor)) m_pend[i] = 1'b1;
    if (m_door_left > 0) begin
      if (r[m_floor]) m_door_left = DT;
      else if (t) m_door_left--;
    end else if (m_motion != 0) begin
      if (t) begin
        m_travel_left--;
        if (m_travel_left == 0) begin
          m_floor += m_motion;
          if (old[m_floor]) begin
            m_pend[m_floor] = 1'b0; m_door_left = DT; m_motion = 0;
          end else if (!beyond(old, m_floor, m_motion)) begin
            m_motion = 0;
          end else begin
            m_travel_left = TT;
          end
        end
      end
    end else if (old[m_floor]) begin
      m_pend[m_floor] = 1'b0; m_door_left = DT;
    end else begin
      a = beyond(old, m_floor, 1);
      b = beyond(old, m_floor, -1);
      if (a && (m_up || !b)) begin m_motion = 1; m_up = 1'b1; m_travel_left = TT; end
      else if (b) begin m_motion = -1; m_up = 1'b0; m_travel_left = TT; end
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [NF-1:0] pv;
    for (int i = 0; i < NF; i++) pv[i] = m_pend[i];
    return {FW'(m_floor), m_motion != 0, m_door_left > 0, m_up, pv};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.current_floor, bus.moving, bus.door_open, bus.dir_up, bus.pending};
  endfunction

  function automatic bit settled();
    for (int i = 0; i < NF; i++) if (m_pend[i]) return 1'b0;
    return m_motion == 0 && m_door_left == 0;
  endfunction

  task automatic cycle(input logic [NF-1:0] r, input logic t);
    bus.req = r; bus.tick = t;
    @(posedge clk_in);
    model_step(r, t);
    #1;
    bus.req = '0; bus.tick = 1'b0;
  endtask

  task automatic tcycle(input logic [NF-1:0] r);
    cycle(r, (cyc % 4) == 3);
    cyc++;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.tick = 1'b0; rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_init got=%b exp=%b", dut_vec(), model_vec());
    end
    tcycle(4'b1000);
    n = 0;
    while (!(m_floor == 2 && m_motion == 1) && n < 200) begin tcycle('0); n++; end
    checks++;
    if (n >= 200 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_premove got=%b exp=%b n=%0d", dut_vec(), model_vec(), n);
    end
    #2 rst = 1'b1;
    #1 model_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_async got=%b exp=%b", dut_vec(), model_vec());
    end
    @(posedge clk_in); #1;
    checks++;
    if (dut_vec() !== {FW'(0), 1'b0, 1'b0, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL reset_held got=%b exp=%b", dut_vec(), {FW'(0), 3'b001, 4'b0000});
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_travel_up();
    int n;
    logic [FW-1:0] seen[$];
    logic [FW-1:0] last;
    do_reset();
    last = '0;
    tcycle(4'b1000);
    n = 0;
    while (!settled() && n < 300) begin
      tcycle('0); n++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL travel_up cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
      if (bus.current_floor != last) begin seen.push_back(bus.current_floor); last = bus.current_floor; end
    end
    checks++;
    if (n >= 300 || seen.size() != 3 || seen[0] != 1 || seen[1] != 2 || seen[2] != 3 ||
        bus.current_floor !== FW'(3) || bus.moving !== 1'b0 || bus.door_open !== 1'b0) begin
      errors++; $display("FAIL travel_up_end floor=%0d steps=%0d exp floor=3 steps=3", bus.current_floor, seen.size());
    end
  endtask

  task automatic test_intermediate_stop();
    int n;
    logic [FW-1:0] doors[$];
    logic was_open;
    do_reset();
    tcycle(4'b1000);
    tcycle('0);
    tcycle('0);
    tcycle(4'b0100);
    n = 0; was_open = 1'b0;
    while (!settled() && n < 400) begin
      tcycle('0); n++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL mid_stop cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
      if (bus.door_open && !was_open) doors.push_back(bus.current_floor);
      was_open = bus.door_open;
    end
    checks++;
    if (n >= 400 || doors.size() != 2 || doors[0] != 2 || doors[1] != 3) begin
      errors++; $display("FAIL mid_stop_order stops=%0d exp stops 2 then 3", doors.size());
    end
  endtask

  task automatic test_scan_reverse();
    int n;
    logic [FW-1:0] doors[$];
    logic was_open;
    do_reset();
    tcycle(4'b0100);
    n = 0;
    while (!settled() && n < 300) begin tcycle('0); n++; end
    checks++;
    if (n >= 300 || dut_vec() !== model_vec() || bus.current_floor !== FW'(2) || bus.dir_up !== 1'b1) begin
      errors++; $display("FAIL scan_setup got=%b exp=%b", dut_vec(), model_vec());
    end
    tcycle(4'b1001);
    n = 0; was_open = 1'b0;
    while (!settled() && n < 600) begin
      tcycle('0); n++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL scan cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
      if (bus.door_open && !was_open) doors.push_back(bus.current_floor);
      was_open = bus.door_open;
    end
    checks++;
    if (n >= 600 || doors.size() != 2 || doors[0] != 3 || doors[1] != 0 ||
        bus.dir_up !== 1'b0 || bus.current_floor !== FW'(0)) begin
      errors++; $display("FAIL scan_order stops=%0d dir_up=%b floor=%0d exp 3 then 0, dir_up=0", doors.size(), bus.dir_up, bus.current_floor);
    end
  endtask

  task automatic test_door_extend();
    int n, ticks;
    logic t;
    do_reset();
    tcycle(4'b0010);
    n = 0;
    while (m_door_left != 1 && n < 300) begin
      tcycle('0); n++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL door_ext_pre cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
    end
    cycle(4'b0010, 1'b0);
    checks++;
    if (n >= 300 || bus.door_open !== 1'b1 || bus.pending[1] !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL door_ext_hold got=%b exp=%b", dut_vec(), model_vec());
    end
    ticks = 0; n = 0;
    while (bus.door_open && n < 100) begin
      t = (cyc % 4) == 3;
      tcycle('0); n++;
      if (t) ticks++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL door_ext cyc=%0d got=%b exp=%b", n, dut_vec(), model_vec());
      end
    end
    checks++;
    if (ticks != DT) begin
      errors++; $display("FAIL door_ext_ticks got=%0d exp=%0d", ticks, DT);
    end
  endtask

  task automatic test_idle_same_floor();
    int n;
    do_reset();
    tcycle(4'b0010);
    n = 0;
    while (!settled() && n < 300) begin tcycle('0); n++; end
    cycle(4'b0010, 1'b0);
    checks++;
    if (n >= 300 || dut_vec() !== model_vec() || bus.pending !== 4'b0010 || bus.door_open !== 1'b0) begin
      errors++; $display("FAIL idle_latch got=%b exp=%b", dut_vec(), model_vec());
    end
    cycle('0, 1'b0);
    checks++;
    if (bus.door_open !== 1'b1 || bus.moving !== 1'b0 || bus.pending !== 4'b0000 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL idle_door got=%b exp door=1 moving=0 pending=0000", dut_vec());
    end
  endtask

  task automatic test_random();
    logic [NF-1:0] r;
    logic t;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 11) == 0) ? NF'($urandom_range(1, (1 << NF) - 1)) : '0;
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        cycle(r, t);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random i=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    bus.req = '0;
    bus.tick = 1'b0;
    model_reset();
    test_reset();
    test_travel_up();
    test_intermediate_stop();
    test_scan_reverse();
    test_door_extend();
    test_idle_same_floor();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
